// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: registered CBZ/CBNZ/B.cond/B decision with an internal
// NZCV register, a one-cycle PCSrc/BranchValid pulse and a Flush window that
// blocks new requests after every taken branch.
// Optional macro BRANCH_STATS_EN adds a saturating taken-branch counter (TakenCount).
module branch_resolve_unit #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned STAT_WIDTH   = 16
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  InValid,
  input  logic                  Branch,
  input  logic                  UncondBranch,
  input  logic [1:0]            BrMode,
  input  logic [3:0]            Cond,
  input  logic [DATA_WIDTH-1:0] RegVal,
  input  logic                  SetFlags,
  input  logic [3:0]            AluFlags,
  output logic                  PCSrc,
  output logic                  BranchValid,
  output logic                  Flush,
  output logic                  Busy,
  output logic [3:0]            Flags
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] TakenCount
`endif
);

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES);

  logic [3:0] flags_q, flags_d;
  logic [3:0] flush_cnt_q, flush_cnt_d;
  logic       pcsrc_q, pcsrc_d;
  logic       valid_q, valid_d;
  logic       busy;
  logic       accept;
  logic       decide;
  logic       cond_hit;
  logic       taken;
  logic       n_f, z_f, c_f, v_f;

  assign busy   = (flush_cnt_q != 4'd0);
  assign accept = InValid & ~busy;
  assign decide = accept & (Branch | UncondBranch);
  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Condition-code evaluation against the flags held before this edge
  always_comb begin
    cond_hit = 1'b1;
    case (Cond)
      4'b0000: cond_hit = z_f;
      4'b0001: cond_hit = ~z_f;
      4'b0010: cond_hit = c_f;
      4'b0011: cond_hit = ~c_f;
      4'b0100: cond_hit = n_f;
      4'b0101: cond_hit = ~n_f;
      4'b0110: cond_hit = v_f;
      4'b0111: cond_hit = ~v_f;
      4'b1000: cond_hit = c_f & ~z_f;
      4'b1001: cond_hit = ~(c_f & ~z_f);
      4'b1010: cond_hit = (n_f == v_f);
      4'b1011: cond_hit = (n_f != v_f);
      4'b1100: cond_hit = ~z_f & (n_f == v_f);
      4'b1101: cond_hit = ~(~z_f & (n_f == v_f));
      default: cond_hit = 1'b1;
    endcase
  end

  // Taken decision; UncondBranch dominates BrMode
  always_comb begin
    taken = 1'b0;
    if (UncondBranch) begin
      taken = 1'b1;
    end else if (Branch) begin
      case (BrMode)
        2'b00:   taken = (RegVal == '0);
        2'b01:   taken = (RegVal != '0);
        2'b10:   taken = cond_hit;
        default: taken = 1'b0;
      endcase
    end
  end

  // Next-state: flags, decision pulse and flush down-counter
  always_comb begin
    flags_d     = flags_q;
    valid_d     = decide;
    pcsrc_d     = decide & taken;
    flush_cnt_d = flush_cnt_q;
    if (accept && SetFlags) begin
      flags_d = AluFlags;
    end
    if (decide && taken) begin
      flush_cnt_d = FlushLoad;
    end else if (busy) begin
      flush_cnt_d = flush_cnt_q - 4'd1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      flags_q     <= 4'b0000;
      flush_cnt_q <= 4'd0;
      pcsrc_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      flush_cnt_q <= flush_cnt_d;
      pcsrc_q     <= pcsrc_d;
      valid_q     <= valid_d;
    end
  end

  assign PCSrc       = pcsrc_q;
  assign BranchValid = valid_q;
  assign Flush       = busy;
  assign Busy        = busy;
  assign Flags       = flags_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_WIDTH-1:0] taken_cnt_q;

  // Saturating taken-branch counter, updated alongside the PCSrc register
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      taken_cnt_q <= '0;
    end else if (pcsrc_d && (taken_cnt_q != '1)) begin
      taken_cnt_q <= taken_cnt_q + 1'b1;
    end
  end

  assign TakenCount = taken_cnt_q;
`else
  // Keeps STAT_WIDTH referenced when statistics are compiled out
  logic [STAT_WIDTH-1:0] unused_stat;
  assign unused_stat = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int unsigned DW  = 64;
  localparam int unsigned FC  = 2;
  localparam int unsigned FC5 = 5;
  localparam int unsigned SW  = 3;
  localparam int          CMAX = (1 << SW) - 1;

  logic          CLOCK, RESET, InValid, Branch, UncondBranch, SetFlags;
  logic [1:0]    BrMode;
  logic [3:0]    Cond, AluFlags;
  logic [DW-1:0] RegVal;

  logic       PCSrc, BranchValid, Flush, Busy;
  logic [3:0] Flags;
  logic       PCSrc5, BranchValid5, Flush5, Busy5;
  logic [3:0] Flags5;
`ifdef BRANCH_STATS_EN
  logic [SW-1:0] TakenCount, unused_tc5;
`endif

  branch_resolve_unit #(.DATA_WIDTH(DW), .FLUSH_CYCLES(FC), .STAT_WIDTH(SW)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .InValid(InValid), .Branch(Branch),
    .UncondBranch(UncondBranch), .BrMode(BrMode), .Cond(Cond), .RegVal(RegVal),
    .SetFlags(SetFlags), .AluFlags(AluFlags), .PCSrc(PCSrc), .BranchValid(BranchValid),
    .Flush(Flush), .Busy(Busy), .Flags(Flags)
`ifdef BRANCH_STATS_EN
    , .TakenCount(TakenCount)
`endif
  );

  branch_resolve_unit #(.DATA_WIDTH(DW), .FLUSH_CYCLES(FC5), .STAT_WIDTH(SW)) dut5 (
    .CLOCK(CLOCK), .RESET(RESET), .InValid(InValid), .Branch(Branch),
    .UncondBranch(UncondBranch), .BrMode(BrMode), .Cond(Cond), .RegVal(RegVal),
    .SetFlags(SetFlags), .AluFlags(AluFlags), .PCSrc(PCSrc5), .BranchValid(BranchValid5),
    .Flush(Flush5), .Busy(Busy5), .Flags(Flags5)
`ifdef BRANCH_STATS_EN
    , .TakenCount(unused_tc5)
`endif
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  int compared = 0;
  int mismatched = 0;

  // Reference model state for the FLUSH_CYCLES=2 instance
  logic [3:0] m_flags;
  int         m_flush;
  bit         m_pcsrc, m_valid;
  int         m_count;

  logic [7:0] obs;
  assign obs = {PCSrc, BranchValid, Flush, Busy, Flags};

  function automatic logic [7:0] exp_vec();
    bit f;
    f = (m_flush > 0);
    return {m_pcsrc, m_valid, f, f, m_flags};
  endfunction

  // ARM ConditionHolds: base test on cc[3:1], inverted by cc[0] except AL
  function automatic bit cond_holds(logic [3:0] f, logic [3:0] cc);
    bit n, z, c, v, r;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: return 1'b1;
    endcase
    return cc[0] ? !r : r;
  endfunction

  function automatic bit branch_taken(bit ub, bit br, logic [1:0] mode, logic [3:0] cc,
                                      logic [DW-1:0] rv, logic [3:0] f);
    if (ub) return 1'b1;
    if (!br) return 1'b0;
    if (mode == 2'd0) return rv == 0;
    if (mode == 2'd1) return rv != 0;
    if (mode == 2'd2) return cond_holds(f, cc);
    return 1'b0;
  endfunction

  task automatic drive(bit v, bit br, bit ub, logic [1:0] m, logic [3:0] c,
                       logic [DW-1:0] r, bit sf, logic [3:0] af);
    InValid = v; Branch = br; UncondBranch = ub; BrMode = m; Cond = c;
    RegVal = r; SetFlags = sf; AluFlags = af;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, '0, 1'b0, 4'd0);
  endtask

  // One clock edge: predict from pre-edge inputs, then sample #1 after the edge
  task automatic tick();
    bit rst, acc, dec, tk, sf;
    logic [3:0] af;
    rst = RESET;
    acc = InValid && (m_flush == 0);
    dec = acc && (Branch || UncondBranch);
    tk  = dec && branch_taken(UncondBranch, Branch, BrMode, Cond, RegVal, m_flags);
    sf  = SetFlags;
    af  = AluFlags;
    @(posedge CLOCK);
    #1;
    if (rst) begin
      m_flags = 4'd0; m_flush = 0; m_pcsrc = 0; m_valid = 0; m_count = 0;
    end else begin
      m_valid = dec;
      m_pcsrc = tk;
      if (acc && sf) m_flags = af;
      if (tk) m_flush = FC;
      else if (m_flush > 0) m_flush--;
      if (tk && m_count < CMAX) m_count++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            2'($urandom), 4'($urandom), {$urandom, $urandom}, $urandom_range(0, 1),
            4'($urandom));
      tick();
      compared++;
      if (obs !== 8'h00) begin
        mismatched++;
        $display("FAIL reset_outputs cycle=%0d got=%b want=%b", i, obs, 8'h00);
      end
    end
    RESET = 1'b0;
    idle();
    tick();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 4'd0, '0, 1'b0, 4'd0);
    tick();
    idle();
    compared++;
    if (obs[7:5] !== 3'b111 || obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL cbz_zero_taken got=%b want=%b", obs, exp_vec());
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      compared++;
      if (Flush !== (i == 0) || obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL cbz_flush_window cycle=%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_cbnz();
    drive(1'b1, 1'b1, 1'b0, 2'b01, 4'd0, 64'h8000_0000_0000_0000, 1'b0, 4'd0);
    tick();
    idle();
    compared++;
    if (PCSrc !== 1'b1 || obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL cbnz_msb_taken got=%b want=%b", obs, exp_vec());
    end
    repeat (FC) tick();
    drive(1'b1, 1'b1, 1'b0, 2'b01, 4'd0, '0, 1'b0, 4'd0);
    tick();
    idle();
    compared++;
    if (obs[7:5] !== 3'b010 || obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL cbnz_zero_not_taken got=%b want=%b", obs, exp_vec());
    end
    tick();
    compared++;
    if (Flush !== 1'b0 || BranchValid !== 1'b0) begin
      mismatched++;
      $display("FAIL cbnz_no_flush got=%b want=%b", obs, exp_vec());
    end
  endtask

  task automatic test_bcond();
    drive(1'b1, 1'b0, 1'b0, 2'b10, 4'd0, '0, 1'b1, 4'b1001);
    tick();
    compared++;
    if (Flags !== 4'b1001 || obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL setflags_only got=%b want=%b", obs, exp_vec());
    end
    drive(1'b1, 1'b1, 1'b0, 2'b10, 4'b1010, '0, 1'b0, 4'd0);
    tick();
    idle();
    compared++;
    if (PCSrc !== 1'b1 || obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL bcond_ge_taken got=%b want=%b", obs, exp_vec());
    end
    repeat (FC) tick();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 4'b1011, '0, 1'b0, 4'd0);
    tick();
    compared++;
    if (obs[7:6] !== 2'b01 || obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL bcond_lt_not_taken got=%b want=%b", obs, exp_vec());
    end
    drive(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, '0, 1'b1, 4'b0000);
    tick();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 4'b0000, '0, 1'b1, 4'b0100);
    tick();
    idle();
    compared++;
    if (obs !== 8'b0100_0100 || obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL bcond_old_flags_decide got=%b want=%b", obs, exp_vec());
    end
  endtask

  task automatic test_uncond_busy();
    drive(1'b1, 1'b0, 1'b1, 2'b11, 4'd0, '1, 1'b0, 4'd0);
    tick();
    idle();
    compared++;
    if (PCSrc !== 1'b1 || obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL uncond_mode11_taken got=%b want=%b", obs, exp_vec());
    end
    tick();
    // Second flush cycle: this request must be dropped, flags included
    drive(1'b1, 1'b0, 1'b1, 2'b00, 4'd0, '0, 1'b1, 4'b1111);
    tick();
    compared++;
    if (BranchValid !== 1'b0 || Flags !== 4'b0100 || obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL busy_request_ignored got=%b want=%b", obs, exp_vec());
    end
    drive(1'b1, 1'b1, 1'b0, 2'b11, 4'd0, '0, 1'b0, 4'd0);
    tick();
    idle();
    compared++;
    if (obs[7:5] !== 3'b010 || obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL after_flush_accepted_mode11 got=%b want=%b", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RESET = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 4) == 0,
            2'($urandom), 4'($urandom),
            ($urandom_range(0, 2) == 0) ? '0 : {$urandom, $urandom},
            $urandom_range(0, 1), 4'($urandom));
      tick();
      compared++;
      if (obs !== exp_vec()) begin
        mismatched++;
        $display("FAIL random_step=%0d got=%b want=%b", i, obs, exp_vec());
      end
`ifdef BRANCH_STATS_EN
      compared++;
      if (TakenCount !== SW'(m_count)) begin
        mismatched++;
        $display("FAIL random_count step=%0d got=%0d want=%0d", i, TakenCount, m_count);
      end
`endif
    end
    RESET = 1'b0;
    idle();
    repeat (FC) tick();
  endtask

  task automatic test_flush5();
    RESET = 1'b1;
    idle();
    tick();
    RESET = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 2'b00, 4'd0, '0, 1'b0, 4'd0);
    tick();
    idle();
    compared++;
    if ({PCSrc5, BranchValid5} !== 2'b11 || Flags5 !== 4'd0) begin
      mismatched++;
      $display("FAIL flush5_taken got=%b%b want=11", PCSrc5, BranchValid5);
    end
    for (int i = 1; i <= 6; i++) begin
      compared++;
      if ({Flush5, Busy5} !== {2{i <= 5}}) begin
        mismatched++;
        $display("FAIL flush5_window cycle=%0d got=%b%b want=%b", i, Flush5, Busy5, i <= 5);
      end
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 2'b00, 4'd0, '0, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    tick();
    compared++;
    if (Flush5 !== 1'b1) begin
      mismatched++;
      $display("FAIL flush5_cycle3_high got=%b want=1", Flush5);
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    compared++;
    if ({Flush5, Busy5, PCSrc5, BranchValid5} !== 4'b0000 || obs !== exp_vec()) begin
      mismatched++;
      $display("FAIL flush5_reset_abort got=%b%b want=00", Flush5, Busy5);
    end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    RESET = 1'b1;
    idle();
    tick();
    RESET = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 1'b0, 1'b1, 2'b00, 4'd0, '0, 1'b0, 4'd0);
      tick();
      idle();
      compared++;
      if (TakenCount !== SW'((i > CMAX) ? CMAX : i)) begin
        mismatched++;
        $display("FAIL stats_count n=%0d got=%0d want=%0d", i, TakenCount,
                 (i > CMAX) ? CMAX : i);
      end
      repeat (FC) tick();
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    compared++;
    if (TakenCount !== '0) begin
      mismatched++;
      $display("FAIL stats_reset got=%0d want=0", TakenCount);
    end
  endtask
`endif

  initial begin
    m_flags = 4'd0; m_flush = 0; m_pcsrc = 0; m_valid = 0; m_count = 0;
    RESET = 1'b1;
    idle();
    test_reset();
    test_cbnz();
    test_bcond();
    test_uncond_busy();
    test_random();
    test_flush5();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, registered successor to the single-gate CBZ/CBNZ branch AND.
- Resolves CBZ, CBNZ, B.cond and B in one block, using a DATA_WIDTH register operand and an internal NZCV flag register.
- Emits a one-cycle PCSrc pulse and holds a pipeline Flush window after every taken branch.
- Sits between the register-read/ALU stage and the PC mux of the LEGv8 datapath.

Parameters:
DATA_WIDTH, 64, width of the register operand tested by CBZ/CBNZ
FLUSH_CYCLES, 2, number of cycles Flush is held after a taken branch (legal range 1..15)
STAT_WIDTH, 16, width of the taken-branch counter (optional feature only)

Ports:
CLOCK  in  1  rising-edge clock
RESET  in  1  synchronous, active-high reset
InValid  in  1  request-valid qualifier for all inputs below
Branch  in  1  conditional branch instruction (CBZ/CBNZ/B.cond)
UncondBranch  in  1  unconditional B
BrMode  in  2  00 CBZ, 01 CBNZ, 10 B.cond, 11 reserved
Cond  in  4  LEGv8 condition code for B.cond
RegVal  in  DATA_WIDTH  operand Rt for CBZ/CBNZ
SetFlags  in  1  flag-setting instruction (ADDS/SUBS/ANDS)
AluFlags  in  4  NZCV from ALU, {N,Z,C,V}
PCSrc  out  1  branch taken, one-cycle pulse
BranchValid  out  1  one-cycle pulse, a branch decision was made
Flush  out  1  squash younger instructions
Busy  out  1  input ignored this cycle; equals Flush
Flags  out  4  current NZCV register
TakenCount  out  STAT_WIDTH  taken branches (BRANCH_STATS_EN only)

Behaviour:
- Reset (CLOCK edge with RESET=1): PCSrc=0, BranchValid=0, Flush=0, Busy=0, Flags=4'b0000, flush counter=0, TakenCount=0.
  - Reset overrides every other input.
  - Reset during a flush window aborts it at that edge.
- Accept: an edge with InValid=1 and Busy=0. Inputs are ignored entirely while Busy=1: no flag update, no decision.
- Flags: on accept with SetFlags=1, Flags<=AluFlags.
- Decision evaluation:
  - A decision is evaluated only on accept with Branch|UncondBranch.
  - B.cond uses the Flags value *before* this edge's update (simultaneous SetFlags+Branch: old flags decide, new flags are stored).
- Taken rule:
  - UncondBranch=1: taken, regardless of Branch/BrMode.
  - Else Branch=1 with BrMode 00: taken iff RegVal==0, all DATA_WIDTH bits compared.
  - BrMode 01: taken iff RegVal!=0.
  - BrMode 10: taken per Cond, ARM semantics:
    - EQ Z, NE !Z, HS C, LO !C, MI N, PL !N, VS V, VC !V
    - HI C&!Z, LS !(C&!Z)
    - GE N==V, LT N!=V
    - GT !Z&(N==V), LE !(!Z&(N==V))
    - 1110 and 1111 always taken.
  - BrMode 11: not taken.
- Latency: decision is registered. Accept at edge k → BranchValid=1 and PCSrc=taken during cycle k+1, both for exactly one cycle. A not-taken branch gives BranchValid=1 with PCSrc=0.
- Flush: a taken decision at edge k drives Flush=Busy=1 for cycles k+1..k+FLUSH_CYCLES via a down-counter loaded with FLUSH_CYCLES. Flush falls after the last cycle. A request at cycle k+FLUSH_CYCLES+1 is accepted.
- Neither Branch nor UncondBranch: BranchValid stays 0 (flag update only).
- Branch=0 and UncondBranch=0 with BrMode/Cond/RegVal toggling: no effect.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - TakenCount port exists.
  - Increments by 1 on each taken decision, in the same edge as the PCSrc register.
  - Saturates at all-ones (no wrap).
  - Cleared by RESET.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- RESET=1 for 2 cycles with random inputs → all outputs 0, Flags=0000. Then CBZ with RegVal=0 → cycle+1: PCSrc=1, BranchValid=1, Flush=1 for exactly 2 cycles.
- CBNZ: RegVal=64'h8000_0000_0000_0000 → taken. RegVal=0 → BranchValid=1, PCSrc=0, Flush stays 0.
- SetFlags with AluFlags=1001 (N=1, V=1), then B.cond GE (1010) → taken. B.cond LT (1011) → not taken.
  - Simultaneous SetFlags=1, AluFlags=0100 with B.cond EQ while Flags=0000 → not taken, then Flags=0100.
- UncondBranch with BrMode=11 → taken. Branch-only with BrMode=11 → not taken. Request issued in the 2nd Flush cycle → ignored; issued the cycle after Flush falls → accepted.
- FLUSH_CYCLES=5: taken branch → Flush high 5 cycles. RESET asserted in flush cycle 3 → Flush=0 next cycle.
- BRANCH_STATS_EN, STAT_WIDTH=3: 9 taken branches → TakenCount=7 (saturated). RESET → 0.
